udiv_iter: RTL

//   Multi-cycle restoring unsigned divider with valid/ready handshakes on input and output.

---
 rtl/udiv_iter_pkg.sv | 20 ++
 rtl/udiv_iter_step.sv | 33 +++
 rtl/udiv_iter.sv | 114 +++++++++++
 3 files changed

// File: rtl/udiv_iter_pkg.sv
// Shared types and constants for the iterative unsigned divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udiv_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Quotient returned for a zero divisor; sliced to WIDTH by the user.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/udiv_iter_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
// Latency: combinational.
// Backpressure: n/a.
//   r      partial remainder (WIDTH+1 bits)   r_next  updated partial remainder
//   q      dividend/quotient shift register   q_next  shifted, new quotient bit in [0]
//   d      divisor
module udiv_step
    import udiv_iter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    // One extra top bit keeps the full incoming r in the compare, so the
    // result is correct even if r ever carried a set MSB.
    logic [WIDTH+1:0] r_sh;

    always_comb begin
        r_sh   = {r, q[WIDTH-1]};
        r_next = r_sh[WIDTH:0];
        q_next = q << 1;
        if (r_sh >= {2'b00, d}) begin
            r_next    = r_sh[WIDTH:0] - {1'b0, d};
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/udiv_iter.sv
// Multi-cycle restoring unsigned divider, one quotient bit per cycle.
// Latency: WIDTH+1 cycles accept-to-valid (1 cycle for a zero divisor).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no operand buffering.
//   CLK, RESETN          clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake, in0 dividend, in1 divisor
//   out_valid/out_ready  result handshake, quot, rem, div_by_zero
module udiv_iter
    import udiv_iter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;       // partial remainder, final remainder in DONE
    logic [WIDTH-1:0] q_q, q_d;       // dividend shift register, final quotient in DONE
    logic [WIDTH-1:0] d_q, d_d;       // captured divisor
    logic [CW-1:0]    cnt_q, cnt_d;   // steps remaining
    logic             dz_q, dz_d;

    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    udiv_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (step_r),
        .q_next (step_q)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in1 == '0) begin
                        // Defined result: all-ones quotient, dividend as remainder.
                        state_d = DONE;
                        q_d     = DIV0_QUOT[WIDTH-1:0];
                        r_d     = {1'b0, in0};
                        dz_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                        r_d     = '0;
                        q_d     = in0;
                        d_d     = in1;
                        cnt_d   = CNT_INIT;
                        dz_d    = 1'b0;
                    end
                end
            end
            BUSY: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
        end
    end

    // All outputs come straight from flops.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quot        = q_q;
    assign rem         = r_q[WIDTH-1:0];
    assign div_by_zero = dz_q;

endmodule
